tdm_tx: RTL
===========

# tdm_tx

Serializes the four signed 16-bit DAC-direction samples produced by the user sample core onto a 4-slot TDM serial stream for the CODEC, generating bit clock, frame clock and serial data from the system clock. It also generates the one-cycle `sample_clk` frame strobe that the sample cores consume, so it is the framing master at the output end of the sample path.

## Interface
- `BCK_DIV`, 4, system-clock cycles per `bick` period; even, ≥ 2. Frame rate = clk / (BCK_DIV·64), which is 46.875 kHz at 12 MHz with the default.
- `clk`  in  1  system clock, 12 MHz.
- `rst`  in  1  reset, synchronous, active-high; one clock, all state in the `clk` domain.
- `mute`  in  1  when high at frame load, the frame is loaded with all zeros.
- `sample_in0`..`sample_in3`  in  16 each  signed two's-complement samples for slots 0..3.
- `sample_clk`  out  1  one-`clk`-cycle strobe, high in the cycle after each frame load.
- `bick`  out  1  TDM bit clock.
- `lrck`  out  1  frame clock, 50% duty.
- `sdout`  out  1  serial data, MSB first.

## Operation
- **State registers:**
  - `div`: 0..BCK_DIV-1.
  - `bitcnt`: 0..63.
  - `shreg`: 64 bits.
  - `sample_clk` register.
- **Reset values:**
  - `div` = BCK_DIV-1, `bitcnt` = 63, `shreg` = 0, `sample_clk` = 0.
  - Resulting outputs during reset: `bick` = 1, `lrck` = 0, `sdout` = 0.
- **`div` counter:** increments every clk and wraps BCK_DIV-1 → 0. `bitcnt` increments on each `div` wrap and wraps 63 → 0.
- **Derived outputs (from registers only, no combinational path from inputs):**
  - `bick` = (div ≥ BCK_DIV/2).
  - `lrck` = ~bitcnt[5], i.e. high for bits 0..31 and low for bits 32..63.
  - `sdout` = shreg[63].
- **Load:** on the edge where div = BCK_DIV-1 and bitcnt = 63:
  - shreg ← {sample_in0, sample_in1, sample_in2, sample_in3}, or 64'h0 if `mute`.
  - `sample_clk` ← 1.
- **Shift:** on every other `div` wrap, shreg ← shreg << 1 with zero fill.
- **`sample_clk` clearing:** cleared on every edge that is not a load edge.
- **Slot layout:** slot k, bit j (15 = MSB) is on `sdout` during `bick` period 16k + (15 - j) of the frame.
- **Arithmetic:** samples pass bit-exact. No scaling, saturation or sign manipulation.
- **Input latching:** inputs are sampled only at the load edge. Changes at any other time affect the next frame only.
- **Reset mid-frame:** the frame in progress is abandoned. Outputs take reset values on the next edge. The first edge after `rst` deasserts is a load edge, so a fresh frame begins immediately and carries the current inputs.
- **`mute` toggling:** toggling mid-frame has no effect on the frame being transmitted.

## Timing
- **Frame period:** exactly 64·BCK_DIV clk (default 256). `sample_clk` pulses once per frame, high for exactly 1 clk.
- **Load to first bit:** 0 cycles. In the cycle after the load edge, `sample_clk` = 1, `bick` = 0, `lrck` = 1, and `sdout` = slot-0 MSB.
- **`sdout` update:** changes only on clk edges where `bick` goes 1 → 0, i.e. the div wrap.
- **Receiver sampling:** the receiver samples on `bick` rising, which falls mid-bit (div = BCK_DIV/2). That gives BCK_DIV/2 clk of setup and hold.
- **`lrck` transitions:** coincide with `bick` falling edges, at the start of bit 0 and bit 32.
- **First frame after reset:** if `rst` deasserts after edge N, the first `sample_clk` pulse is in the cycle after edge N+1. Subsequent pulses follow every 64·BCK_DIV clk.
- **Input requirement:** inputs need to be stable only around the load edge. The user core has a full frame period to produce them after a `sample_clk` pulse.

## Test plan
1. **Reset values:** hold `rst` for 5 clk → `bick` = 1, `lrck` = 0, `sdout` = 0, `sample_clk` = 0 throughout. Release → `sample_clk` = 1 exactly 2 clk after deassertion, then every 256 clk.
2. **Serialization:** inputs 16'h8001, 16'h7FFE, 16'h1234, 16'hFFFF with the default BCK_DIV → a bench receiver sampling `sdout` on `bick` rising recovers exactly these four words in slots 0..3. Each frame has 64 `bick` periods, and `lrck` is high for the first 32.
3. **Mid-frame input change:** change `sample_in0` from 16'h8001 to 16'h0000 at bit 5 → the current frame still carries 16'h8001 and the next frame carries 16'h0000. Other slots are unchanged.
4. **Mute:** `mute` = 1 at load with nonzero inputs → all 64 bits = 0. Dropping `mute` mid-frame leaves the frame at zero, and the next frame carries the inputs.
5. **Reset mid-frame:** assert `rst` at bitcnt = 20 for 3 clk → outputs take reset values on the next edge. After release, a new full frame starts with no truncated bits and carries the current inputs.
6. **Minimum divider:** `BCK_DIV` = 2 → `bick` toggles every clk, the frame is 128 clk, and the step-2 data recovers bit-exact.

Source files
------------

// File: rtl/tdm_tx.sv
// tdm_tx: 4-slot TDM transmitter and framing master for the DAC direction.
// Generates bick/lrck/sdout from the system clock and a one-cycle
// sample_clk strobe that tells the sample cores a new frame was loaded.
// Each 64-bit frame carries slot 0..3 MSB first, one bit per bick period.
module tdm_tx #(
  parameter int BCK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mute,
  input  logic signed [15:0] sample_in0,
  input  logic signed [15:0] sample_in1,
  input  logic signed [15:0] sample_in2,
  input  logic signed [15:0] sample_in3,
  output logic               sample_clk,
  output logic               bick,
  output logic               lrck,
  output logic               sdout
);

  localparam int DIV_W = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCK_DIV / 2);

  // An odd or sub-2 divider cannot give a centred bick rising edge.
  generate
    if (BCK_DIV < 2 || (BCK_DIV % 2) != 0) begin : g_bad_div
      $error("tdm_tx: BCK_DIV must be even and >= 2");
    end
  endgenerate

  logic [DIV_W-1:0] div;      // clk phase inside the current bick period
  logic [5:0]       bitcnt;   // bick period index inside the frame
  logic [63:0]      shreg;    // frame being transmitted, bit 63 on the wire
  logic             bit_end;  // last clk of a bick period
  logic             frame_load;

  assign bit_end    = (div == DIV_LAST);
  assign frame_load = bit_end && (bitcnt == 6'd63);

  // Divider, bit counter, frame shift register and frame strobe.
  // Reset parks the counters on the last clk of bit 63, so the first edge
  // after release is a load edge and a fresh frame starts immediately.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register reading the
    // pre-edge value of the others, which the load/shift decode relies on.
    if (rst) begin
      div        <= DIV_LAST;
      bitcnt     <= 6'd63;
      shreg      <= 64'h0;
      sample_clk <= 1'b0;
    end else begin
      sample_clk <= frame_load;

      if (bit_end) begin
        div    <= '0;
        bitcnt <= bitcnt + 6'd1;
      end else begin
        div    <= div + DIV_W'(1);
      end

      if (frame_load) begin
        shreg <= mute ? 64'h0 : {sample_in0, sample_in1, sample_in2, sample_in3};
      end else if (bit_end) begin
        shreg <= {shreg[62:0], 1'b0};
      end
    end
  end

  // Serial outputs decode registers only: bick falls on the div wrap, where
  // sdout and lrck change, and rises mid-bit for the receiver to sample.
  assign bick  = (div >= DIV_HALF);
  assign lrck  = ~bitcnt[5];
  assign sdout = shreg[63];

endmodule
